// File: rtl/stream_demux_reg.sv
// Registered 1-to-N stream demux: one held entry, per-channel pending bits,
// broadcast, and drop reporting for out-of-range unicast selects.
module stream_demux_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic hit,
  input  logic ready,
  output logic pend,
  output logic drain
);
  assign drain = pend & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pend <= 1'b0;
    else if (load) pend <= hit;
    else           pend <= drain;
  end
endmodule

module stream_demux_reg #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  input  logic [DATA_W-1:0] in_data,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);
  if ((1 << SEL_W) < N_CH) begin : g_bad_sel
    $error("stream_demux_reg: SEL_W too narrow for N_CH");
  end
  if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
    $error("stream_demux_reg: N_CH must be 2..16");
  end

  logic [N_CH-1:0] pend, drain, hit;
  logic            accept, oor, load;

  // Entry is free when every still-pending channel transfers this cycle.
  assign in_ready = en & ~(|drain);
  assign accept   = in_valid & in_ready;
  assign oor      = ~in_bcast & (32'(in_sel) >= N_CH);
  assign load     = accept & ~oor;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign hit[i] = in_bcast | (32'(in_sel) == 32'(i));
    stream_demux_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .hit   (hit[i]),
      .ready (out_ready[i]),
      .pend  (pend[i]),
      .drain (drain[i])
    );
  end

  assign out_valid = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      err_pulse <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (load) out_data <= in_data;
      // A dropped word still consumes the handshake; only the counters move.
      if (accept && oor) begin
        err_pulse <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end else begin
        err_pulse <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_demux_reg.sv
// Directed bench for stream_demux_reg: a 4-channel instance for delivery and a
// 3-channel, 2-bit-counter instance for out-of-range drops and saturation.
module tb_stream_demux_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       en, in_valid, in_ready, in_bcast, err_pulse;
  logic [1:0] in_sel;
  logic [7:0] in_data, out_data, drop_cnt;
  logic [3:0] out_valid, out_ready;

  logic       b_en, b_in_valid, b_in_ready, b_in_bcast, b_err_pulse;
  logic [1:0] b_in_sel, b_drop_cnt;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_out_valid, b_out_ready;

  stream_demux_reg u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_pulse(err_pulse), .drop_cnt(drop_cnt)
  );

  stream_demux_reg #(.N_CH(3), .DATA_W(8), .SEL_W(2), .CNT_W(2)) u_oor (
    .clk(clk), .rst_n(rst_n), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_bcast(b_in_bcast), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .err_pulse(b_err_pulse), .drop_cnt(b_drop_cnt)
  );

  int errs = 0, checks = 0;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus on the 4-channel instance; accepted words go
  // to the scoreboard and are compared right after the loading edge.
  task automatic step(input string tag, input logic e, input logic v, input logic b,
                      input logic [1:0] s, input logic [7:0] d, input logic [3:0] r,
                      input logic exp_rdy);
    logic [3:0] m;
    exp_t x;
    en = e; in_valid = v; in_bcast = b; in_sel = s; in_data = d; out_ready = r;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
    m = 4'b0001 << s;
    if (b) m = 4'b1111;
    if (v && exp_rdy) sb.push_back('{m, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, " out_valid"}, 32'(out_valid), 32'(x.mask));
      chk({tag, " out_data"}, 32'(out_data), 32'(x.data));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    b_en = 1'b1; b_in_valid = 1'b0; b_in_bcast = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst err_pulse", 32'(err_pulse), 0);
    chk("rst drop_cnt", 32'(drop_cnt), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: back-to-back unicast
    for (int i = 0; i < 4; i++)
      step($sformatf("uni%0d", i), 1, 1, 0, 2'(i), 8'hA0 + 8'(i), 4'b1111, 1);

    // 2: backpressure on channel 2
    step("bp load", 1, 1, 0, 2'd2, 8'h55, 4'b1011, 1);
    step("bp stall", 1, 1, 0, 2'd1, 8'h66, 4'b1011, 0);
    chk("bp stall out_valid", 32'(out_valid), 32'h4);
    chk("bp stall out_data", 32'(out_data), 32'h55);
    step("bp release", 1, 1, 0, 2'd1, 8'h66, 4'b1111, 1);

    // 3: broadcast with staggered readies
    step("bc load", 1, 1, 1, 2'd0, 8'h3C, 4'b1111, 1);
    step("bc c1", 1, 0, 0, 2'd0, 8'h00, 4'b0001, 0);
    chk("bc c1 out_valid", 32'(out_valid), 32'hE);
    chk("bc c1 out_data", 32'(out_data), 32'h3C);
    step("bc c2", 1, 0, 0, 2'd0, 8'h00, 4'b0110, 0);
    chk("bc c2 out_valid", 32'(out_valid), 32'h8);
    step("bc c3", 1, 0, 0, 2'd0, 8'h00, 4'b1000, 1);
    chk("bc c3 out_valid", 32'(out_valid), 32'h0);

    // 4: out-of-range drops and counter saturation on the 3-channel instance
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hEE;
    #1;
    chk("oor in_ready", 32'(b_in_ready), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("oor%0d err_pulse", k), 32'(b_err_pulse), 1);
      chk($sformatf("oor%0d drop_cnt", k), 32'(b_drop_cnt), (k < 3) ? k + 1 : 3);
      chk($sformatf("oor%0d out_valid", k), 32'(b_out_valid), 0);
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("oor idle err_pulse", 32'(b_err_pulse), 0);
    chk("oor idle drop_cnt", 32'(b_drop_cnt), 3);
    chk("oor out_data held", 32'(b_out_data), 0);

    // 5: enable gating while an entry drains
    step("en load", 1, 1, 0, 2'd0, 8'h77, 4'b0000, 1);
    step("en off hold", 0, 0, 0, 2'd0, 8'h00, 4'b0000, 0);
    chk("en off out_valid", 32'(out_valid), 32'h1);
    step("en off drain", 0, 0, 0, 2'd0, 8'h00, 4'b0001, 0);
    chk("en drained out_valid", 32'(out_valid), 32'h0);
    step("en off empty", 0, 0, 0, 2'd0, 8'h00, 4'b0000, 0);
    step("en back", 1, 0, 0, 2'd0, 8'h00, 4'b0000, 1);

    // 6: async reset with a partial broadcast mask and a live err_pulse
    step("rb load", 1, 1, 1, 2'd0, 8'hC3, 4'b0000, 1);
    b_in_valid = 1'b1; b_in_sel = 2'd3;
    step("rb partial", 1, 0, 0, 2'd0, 8'h00, 4'b0101, 0);
    b_in_valid = 1'b0;
    chk("rb partial out_valid", 32'(out_valid), 32'hA);
    chk("rb b err_pulse", 32'(b_err_pulse), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb async out_valid", 32'(out_valid), 0);
    chk("rb async drop_cnt", 32'(drop_cnt), 0);
    chk("rb async err_pulse", 32'(err_pulse), 0);
    chk("rb async b err_pulse", 32'(b_err_pulse), 0);
    chk("rb async b drop_cnt", 32'(b_drop_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;
    #1;
    chk("rb release in_ready", 32'(in_ready), 1);
    en = 1'b0;
    #1;
    chk("rb en0 in_ready", 32'(in_ready), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/stream_demux_reg.md
# stream_demux_reg

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking on the input and on every output channel. It is the next generation of the small enable-gated 1-to-4 demux. It adds:
- a one-entry output register stage;
- per-channel backpressure;
- a broadcast mode that delivers one word to all channels;
- error reporting for out-of-range selects.

It sits between a single producer and N consumer lanes in the lab datapath.

## Interface
Parameters:
- N_CH, 4, number of output channels (2..16)
- DATA_W, 8, data word width
- SEL_W, 2, select width; 2^SEL_W >= N_CH is required, otherwise elaboration fails
- CNT_W, 8, width of the drop counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  acceptance enable; when 0, in_ready is 0, and the held entry still drains
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- in_sel  in  SEL_W  destination channel
- in_bcast  in  1  deliver the word to all N_CH channels; in_sel is ignored
- in_data  in  DATA_W  payload
- out_valid  out  N_CH  per-channel valid (pending mask)
- out_ready  in  N_CH  per-channel ready
- out_data  out  DATA_W  held payload, shared by all channels
- err_pulse  out  1  one-cycle pulse when an out-of-range unicast word is dropped
- drop_cnt  out  CNT_W  saturating count of dropped words

Reset: the polarity (active-low) and asynchronous behaviour of rst_n are fixed.

## Operation
- State:
  - pending mask P[N_CH-1:0], visible directly as out_valid;
  - data register, visible as out_data;
  - err_pulse register;
  - drop_cnt.
- Reset values: P=0, out_data=0, err_pulse=0, drop_cnt=0, so in_ready = en after reset.
- Delivery: channel i completes when P[i] & out_ready[i]. Completed bits clear at the next edge. Channels complete independently and in any order.
- Release: P_next_drain = P & ~out_ready. The entry is free this cycle when P_next_drain == 0. This includes P==0 and the case where the last pending channels all accept this cycle.
- in_ready = en & (P_next_drain == 0). in_ready is combinational from P, out_ready and en. It must not depend on in_valid.
- Accept = in_valid & in_ready. On accept:
  - in_bcast=1: P <= all ones; data <= in_data.
  - in_bcast=0, in_sel < N_CH: P <= onehot(in_sel); data <= in_data.
  - in_bcast=0, in_sel >= N_CH: the word is dropped. P <= P_next_drain (which is 0). data is unchanged. err_pulse <= 1. drop_cnt increments and saturates at 2^CNT_W-1.
- No accept: P <= P_next_drain; data holds; err_pulse <= 0.
- out_data stays stable while any bit of P is set. After the entry drains, out_data keeps its last value (don't-care to consumers).
- Boundary conditions:
  - en dropping mid-entry does not clear P.
  - An out_ready high on a channel whose P bit is 0 has no effect.
  - When N_CH == 2^SEL_W, the out-of-range path is unreachable.
- Asserting rst_n low at any time, including mid-broadcast with a partial mask, clears P, err_pulse and drop_cnt immediately, independent of clk.

## Timing
- Latency: the word accepted at edge k appears on out_valid/out_data right after edge k (1 cycle).
- Unicast throughput is 1 word/cycle when the destination out_ready is held high. Back-to-back accepts overwrite the entry at the same edge the previous one releases.
- A broadcast occupies the entry until the slowest channel accepts. Minimum occupancy is 1 cycle, when all out_ready bits are high.
- Once set, out_valid[i] holds until out_ready[i] is sampled high. It never drops without a transfer, except on reset.
- err_pulse is high for exactly one cycle per dropped word, in the cycle after the accept edge. Consecutive drops keep it high continuously.
- There are no combinational paths from in_valid/in_data to any output.

## Test plan
1. Reset then unicast. Release rst_n; en=1, out_ready=4'b1111. Send sel=0..3 with data 0xA0..0xA3 back to back. Required: in_ready=1 every cycle; out_valid walks 0001, 0010, 0100, 1000 with out_data 0xA0..0xA3, one cycle after each accept.
2. Backpressure. out_ready[2]=0; send sel=2, data 0x55, then sel=1, data 0x66. Required: out_valid=0100 and in_ready=0 while stalled. Then raise out_ready[2]. Required: in_ready=1 that same cycle, 0x66 is accepted, and the next cycle shows out_valid=0010.
3. Broadcast with staggered readies. bcast=1, data 0x3C; out_ready goes 0001, 0110, 1000 on consecutive cycles. Required: out_valid goes 1111, 1110, 1000, 0000; in_ready is 1 only in the third cycle.
4. Out-of-range select. N_CH=3, SEL_W=2; send sel=3 three times. Required: err_pulse high for three consecutive cycles, drop_cnt=3, out_valid stays 000. Separately, with CNT_W=2, send five drops. Required: drop_cnt saturates at 3.
5. Enable gating. Hold a unicast entry to ch0 with out_ready=0; drop en to 0, then raise out_ready[0]. Required: the entry drains (out_valid goes 0001 then 0000) and in_ready stays 0 until en returns to 1.
6. Reset mid-broadcast. With P=1010 after a partial broadcast, pulse rst_n low between clock edges. Required: out_valid=0000, drop_cnt=0 and err_pulse=0 immediately, without waiting for a clock edge; in_ready=en after release.
